// File: rtl/inert_sched_pkg.sv
// Shared types and constants for the inertial-sensor command sequencer.
// Holds the FSM state encoding, the fixed command words and the power-up default.
package inert_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_CFG      = 3'd1,
    ST_IDLE     = 3'd2,
    ST_RD_L     = 3'd3,
    ST_RD_H     = 3'd4,
    ST_HOST     = 3'd5
  } state_e;

  localparam logic [15:0] INIT_CYC_DEFAULT = 16'd65535;

  localparam logic [15:0] CFG_CMD_0 = 16'h0D02;
  localparam logic [15:0] CFG_CMD_1 = 16'h1053;
  localparam logic [15:0] CFG_CMD_2 = 16'h1150;
  localparam logic [15:0] CFG_CMD_3 = 16'h1460;

  localparam logic [15:0] RD_L_CMD  = 16'hA600;
  localparam logic [15:0] RD_H_CMD  = 16'hA700;

  localparam logic [1:0]  CFG_LAST_IDX = 2'd3;

  // Configuration write selected by the 2-bit sequence index.
  function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
    logic [15:0] c;
    case (idx)
      2'd0:    c = CFG_CMD_0;
      2'd1:    c = CFG_CMD_1;
      2'd2:    c = CFG_CMD_2;
      default: c = CFG_CMD_3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/inert_sched_int_sync.sv
// Two-flop synchronizer for an asynchronous sensor line, followed by a
// rising-edge detector producing a single-cycle pulse in the clk domain.
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_sync_q;

endmodule

// File: rtl/inert_sched.sv
// Sequencer/arbiter in front of the SPI monarch for the inertial sensor:
// power-up wait, config writes, yaw reads on INT, optional host port (INERT_HOST_PORT_EN).
module inert_sched
  import inert_pkg::*;
#(
  parameter logic [15:0] INIT_CYC = INIT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  input  logic        host_req,
  input  logic [15:0] host_cmd,
  output logic        host_gnt,
  output logic        host_done,
  output logic [15:0] host_resp,
  output logic [15:0] yaw_rt,
  output logic        vld
);

  state_e      r_state;
  state_e      w_state_next;

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [1:0]  r_cfg_idx;
  logic [1:0]  w_cfg_idx_next;
  logic        r_int_pend;
  logic        w_int_pend_next;
  logic [7:0]  r_low;
  logic [7:0]  w_low_next;
  logic        r_done_q;

  logic        r_snd;
  logic        w_snd_next;
  logic [15:0] r_cmd;
  logic [15:0] w_cmd_next;
  logic        r_host_gnt;
  logic        w_host_gnt_next;
  logic        r_host_done;
  logic        w_host_done_next;
  logic [15:0] r_host_resp;
  logic [15:0] w_host_resp_next;
  logic [15:0] r_yaw;
  logic [15:0] w_yaw_next;
  logic        r_vld;
  logic        w_vld_next;

  logic        w_int_rise;
  logic        w_cpl;
  logic        w_want_rd;
  logic        w_pwr_done;
  logic        w_host_req;
  logic [15:0] w_host_cmd;

  int_sync u_int_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (INT),
    .o_rise  (w_int_rise)
  );

  // done stays high from the previous transaction through the issue cycle,
  // so only its rising edge marks completion.
  assign w_cpl      = done & ~r_done_q;
  assign w_want_rd  = r_int_pend | w_int_rise;
  assign w_pwr_done = (r_cnt == INIT_CYC);

`ifdef INERT_HOST_PORT_EN
  assign w_host_req = host_req;
  assign w_host_cmd = host_cmd;
  assign host_gnt   = r_host_gnt;
  assign host_done  = r_host_done;
  assign host_resp  = r_host_resp;
`else
  logic w_unused_host;
  assign w_host_req    = 1'b0;
  assign w_host_cmd    = 16'h0000;
  assign host_gnt      = 1'b0;
  assign host_done     = 1'b0;
  assign host_resp     = 16'h0000;
  assign w_unused_host = ^{host_req, host_cmd, resp[15:8],
                           r_host_gnt, r_host_done, r_host_resp};
`endif

  assign snd    = r_snd;
  assign cmd    = r_cmd;
  assign yaw_rt = r_yaw;
  assign vld    = r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PWR_WAIT;
      r_cnt       <= 16'h0000;
      r_cfg_idx   <= 2'd0;
      r_int_pend  <= 1'b0;
      r_low       <= 8'h00;
      r_done_q    <= 1'b0;
      r_snd       <= 1'b0;
      r_cmd       <= 16'h0000;
      r_host_gnt  <= 1'b0;
      r_host_done <= 1'b0;
      r_host_resp <= 16'h0000;
      r_yaw       <= 16'h0000;
      r_vld       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_cfg_idx   <= w_cfg_idx_next;
      r_int_pend  <= w_int_pend_next;
      r_low       <= w_low_next;
      r_done_q    <= done;
      r_snd       <= w_snd_next;
      r_cmd       <= w_cmd_next;
      r_host_gnt  <= w_host_gnt_next;
      r_host_done <= w_host_done_next;
      r_host_resp <= w_host_resp_next;
      r_yaw       <= w_yaw_next;
      r_vld       <= w_vld_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PWR_WAIT: if (w_pwr_done) w_state_next = ST_CFG;
      ST_CFG:      if (w_cpl && (r_cfg_idx == CFG_LAST_IDX)) w_state_next = ST_IDLE;
      ST_IDLE: begin
        if (w_want_rd)       w_state_next = ST_RD_L;
        else if (w_host_req) w_state_next = ST_HOST;
      end
      ST_RD_L:     if (w_cpl) w_state_next = ST_RD_H;
      ST_RD_H:     if (w_cpl) w_state_next = ST_IDLE;
      ST_HOST:     if (w_cpl) w_state_next = ST_IDLE;
      default:     w_state_next = ST_PWR_WAIT;
    endcase
  end

  // Every issue is decided in the same cycle as the event that enables it,
  // so the next snd follows a completion edge by exactly one cycle.
  always_comb begin
    w_cnt_next       = r_cnt;
    w_cfg_idx_next   = r_cfg_idx;
    w_int_pend_next  = r_int_pend | w_int_rise;
    w_low_next       = r_low;
    w_snd_next       = 1'b0;
    w_cmd_next       = r_cmd;
    w_host_gnt_next  = 1'b0;
    w_host_done_next = 1'b0;
    w_host_resp_next = r_host_resp;
    w_yaw_next       = r_yaw;
    w_vld_next       = 1'b0;
    case (r_state)
      ST_PWR_WAIT: begin
        if (w_pwr_done) begin
          w_cfg_idx_next = 2'd0;
          w_snd_next     = 1'b1;
          w_cmd_next     = cfg_cmd(2'd0);
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      ST_CFG: begin
        if (w_cpl && (r_cfg_idx != CFG_LAST_IDX)) begin
          w_cfg_idx_next = r_cfg_idx + 2'd1;
          w_snd_next     = 1'b1;
          w_cmd_next     = cfg_cmd(r_cfg_idx + 2'd1);
        end
      end
      ST_IDLE: begin
        if (w_want_rd) begin
          // An edge already pending plus a fresh one leaves one read still owed.
          w_int_pend_next = r_int_pend & w_int_rise;
          w_snd_next      = 1'b1;
          w_cmd_next      = RD_L_CMD;
        end else if (w_host_req) begin
          w_snd_next      = 1'b1;
          w_cmd_next      = w_host_cmd;
          w_host_gnt_next = 1'b1;
        end
      end
      ST_RD_L: begin
        if (w_cpl) begin
          w_low_next = resp[7:0];
          w_snd_next = 1'b1;
          w_cmd_next = RD_H_CMD;
        end
      end
      ST_RD_H: begin
        if (w_cpl) begin
          w_yaw_next = {resp[7:0], r_low};
          w_vld_next = 1'b1;
        end
      end
      ST_HOST: begin
        if (w_cpl) begin
`ifdef INERT_HOST_PORT_EN
          w_host_resp_next = resp;
          w_host_done_next = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inert_sched.sv
// Self-checking bench for inert_sched: SPI monarch model with random latency and
// responses, directed scenarios, expectations derived from the command-sequencing rules.
module tb_inert_sched;

  localparam logic [15:0] INIT = 16'd20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] resp = 16'h0000;
  logic        host_req = 1'b0;
  logic [15:0] host_cmd = 16'h0000;
  logic        snd;
  logic [15:0] cmd;
  logic        host_gnt;
  logic        host_done;
  logic [15:0] host_resp;
  logic [15:0] yaw_rt;
  logic        vld;

  inert_sched #(.INIT_CYC(INIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (INT),
    .snd       (snd),
    .cmd       (cmd),
    .done      (done),
    .resp      (resp),
    .host_req  (host_req),
    .host_cmd  (host_cmd),
    .host_gnt  (host_gnt),
    .host_done (host_done),
    .host_resp (host_resp),
    .yaw_rt    (yaw_rt),
    .vld       (vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int proto_err = 0;
  int cyc = 0;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monarch model state and transaction logs
  bit          busy = 1'b0;
  int          lat = 0;
  int          lat_override = 0;
  int          gnt_total = 0;
  logic [15:0] cur_cmd = 16'h0000;
  logic [7:0]  lo_val = 8'h00;
  logic [7:0]  hi_val = 8'h00;
  logic [31:0] rnd;
  logic [15:0] cmd_log[$];
  int          snd_cyc[$];
  bit          gnt_log[$];
  int          done_cyc[$];
  logic [15:0] resp_log[$];
  logic [15:0] vld_yaw[$];
  int          vld_cyc[$];
  logic [15:0] hd_resp[$];
  int          hd_cyc[$];

  initial begin : monarch
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        done = 1'b0;
      end else begin
        if (snd) begin
          if (busy) proto_err++;
          busy    = 1'b1;
          done    = 1'b0;
          cur_cmd = cmd;
          lat     = (lat_override > 0) ? lat_override : int'($urandom_range(1, 4));
          lat_override = 0;
          cmd_log.push_back(cmd);
          snd_cyc.push_back(cyc);
          gnt_log.push_back(host_gnt);
          $display("txn issue  cyc=%0d cmd=%h gnt=%0b", cyc, cmd, host_gnt);
        end else if (busy) begin
          if (cmd !== cur_cmd) proto_err++;
          lat--;
          if (lat == 0) begin
            busy = 1'b0;
            rnd  = $urandom;
            if (cur_cmd == 16'hA600)      resp = {rnd[15:8], lo_val};
            else if (cur_cmd == 16'hA700) resp = {rnd[15:8], hi_val};
            else                          resp = rnd[15:0];
            done = 1'b1;
            done_cyc.push_back(cyc);
            resp_log.push_back(resp);
            $display("txn done   cyc=%0d cmd=%h resp=%h", cyc, cur_cmd, resp);
          end
        end
        if (host_gnt) begin
          gnt_total++;
          if (!snd) proto_err++;
        end
        if (vld) begin
          vld_yaw.push_back(yaw_rt);
          vld_cyc.push_back(cyc);
        end
        if (host_done) begin
          hd_resp.push_back(host_resp);
          hd_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    cmd_log.delete(); snd_cyc.delete(); gnt_log.delete();
    done_cyc.delete(); resp_log.delete();
    vld_yaw.delete(); vld_cyc.delete(); hd_resp.delete(); hd_cyc.delete();
    gnt_total = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {12'h000, snd, cmd, host_gnt, host_done, vld}, 32'h0);
    chk({tag, "_host_resp"}, host_resp, 32'h0);
    chk({tag, "_yaw"}, yaw_rt, 32'h0);
  endtask

  task automatic chk_seq(input string tag, input logic [15:0] exp_q[$]);
    chk({tag, "_len"}, cmd_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_q[i]);
  endtask

  task automatic wait_snd(input logic [15:0] c, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step(1);
      if (snd && cmd == c) ok = 1'b1;
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_gnt(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step(1);
      if (host_gnt) ok = 1'b1;
    end
    chk(tag, ok, 1);
  endtask

  // The four configuration writes, in order, one per completion.
  task automatic chk_cfg(input string tag);
    chk({tag, "_first_snd_cyc"}, snd_cyc.size() > 0 ? snd_cyc[0] : -1, 21);
    for (int i = 0; i < 3; i++)
      if (snd_cyc.size() > i + 1 && done_cyc.size() > i)
        chk($sformatf("%s_reissue_gap%0d", tag, i), snd_cyc[i+1] - done_cyc[i], 1);
      else
        chk($sformatf("%s_reissue_missing%0d", tag, i), 0, 1);
  endtask

  logic [15:0] eq[$];
  logic [15:0] hc;
  int          ic;

  initial begin
    step(3);
    chk_reset("reset0");
    rst_n = 1'b1;

    // Config sequence, host request raised while config is running
    step(23);
    hc = 16'h8F00;
    host_req = 1'b1;
    host_cmd = hc;
`ifdef INERT_HOST_PORT_EN
    wait_gnt("cfg_host_gnt_seen");
    host_req = 1'b0;
    step(30);
`else
    step(60);
    host_req = 1'b0;
    step(20);
`endif
    eq.delete();
    eq.push_back(16'h0D02); eq.push_back(16'h1053);
    eq.push_back(16'h1150); eq.push_back(16'h1460);
`ifdef INERT_HOST_PORT_EN
    eq.push_back(hc);
`endif
    chk_seq("cfg", eq);
    chk_cfg("cfg");
`ifdef INERT_HOST_PORT_EN
    chk("cfg_gnt_total", gnt_total, 1);
    chk("cfg_gnt_with_host_snd", gnt_log.size() > 4 ? gnt_log[4] : 1'b0, 1);
    chk("cfg_host_done_cnt", hd_resp.size(), 1);
    if (hd_resp.size() > 0 && resp_log.size() > 4) begin
      chk("cfg_host_resp", hd_resp[0], resp_log[4]);
      chk("cfg_host_done_lat", hd_cyc[0] - done_cyc[4], 1);
    end
`else
    chk("cfg_no_gnt", gnt_total, 0);
`endif

    // Single yaw read with the directed bytes 0x34 / 0x12
    clear_logs();
    lo_val = 8'h34;
    hi_val = 8'h12;
    INT = 1'b1;
    ic = cyc;
    step(3);
    INT = 1'b0;
    step(60);
    eq.delete();
    eq.push_back(16'hA600); eq.push_back(16'hA700);
    chk_seq("rd1", eq);
    chk("rd1_vld_cnt", vld_yaw.size(), 1);
    if (vld_yaw.size() > 0 && done_cyc.size() > 1 && snd_cyc.size() > 1) begin
      chk("rd1_yaw", vld_yaw[0], 16'h1234);
      chk("rd1_vld_lat", vld_cyc[0] - done_cyc[1], 1);
      chk("rd1_rdh_gap", snd_cyc[1] - done_cyc[0], 1);
      chk("rd1_int_lat", snd_cyc[0] - ic, 3);
    end
    chk("rd1_yaw_hold", yaw_rt, 16'h1234);

    // INT and host request in the same idle window, then INT during the host txn
    clear_logs();
    lo_val = 8'($urandom);
    hi_val = 8'($urandom);
    hc = {4'h8, 12'($urandom)};
    INT = 1'b1;
    step(2);
    host_req = 1'b1;
    host_cmd = hc;
    step(1);
    INT = 1'b0;
    wait_snd(16'hA700, "mix_rdh_seen");
    lat_override = 12;
`ifdef INERT_HOST_PORT_EN
    wait_gnt("mix_host_gnt_seen");
    host_req = 1'b0;
`endif
    INT = 1'b1;
    step(3);
    INT = 1'b0;
    step(80);
    host_req = 1'b0;
    eq.delete();
    eq.push_back(16'hA600); eq.push_back(16'hA700);
`ifdef INERT_HOST_PORT_EN
    eq.push_back(hc);
`endif
    eq.push_back(16'hA600); eq.push_back(16'hA700);
    chk_seq("mix", eq);
    chk("mix_vld_cnt", vld_yaw.size(), 2);
    if (vld_yaw.size() > 1) chk("mix_yaw", vld_yaw[1], {hi_val, lo_val});
`ifdef INERT_HOST_PORT_EN
    chk("mix_host_done_cnt", hd_resp.size(), 1);
    if (hd_resp.size() > 0 && resp_log.size() > 2) chk("mix_host_resp", hd_resp[0], resp_log[2]);
`else
    chk("mix_no_gnt", gnt_total, 0);
`endif

    // Three INT edges during one long RD_L collapse into one extra read
    clear_logs();
    lo_val = 8'($urandom);
    hi_val = 8'($urandom);
    lat_override = 25;
    INT = 1'b1;
    wait_snd(16'hA600, "multi_rdl_seen");
    INT = 1'b0;
    step(2);
    for (int i = 0; i < 3; i++) begin
      INT = 1'b1;
      step(2);
      INT = 1'b0;
      step(2);
    end
    step(150);
    eq.delete();
    eq.push_back(16'hA600); eq.push_back(16'hA700);
    eq.push_back(16'hA600); eq.push_back(16'hA700);
    chk_seq("multi", eq);
    chk("multi_vld_cnt", vld_yaw.size(), 2);
    if (vld_yaw.size() > 0) chk("multi_yaw", vld_yaw[0], {hi_val, lo_val});

    // Reset during RD_H, host request held across reset
    clear_logs();
    INT = 1'b1;
    wait_snd(16'hA700, "rst_rdh_seen");
    INT = 1'b0;
    step(1);
    rst_n = 1'b0;
    #1;
    chk_reset("reset_mid");
    hc = 16'h8F00;
    host_req = 1'b1;
    host_cmd = hc;
    step(3);
    chk_reset("reset_hold");
    clear_logs();
    rst_n = 1'b1;
`ifdef INERT_HOST_PORT_EN
    wait_gnt("rst_host_gnt_seen");
    host_req = 1'b0;
    step(30);
`else
    step(80);
    host_req = 1'b0;
`endif
    eq.delete();
    eq.push_back(16'h0D02); eq.push_back(16'h1053);
    eq.push_back(16'h1150); eq.push_back(16'h1460);
`ifdef INERT_HOST_PORT_EN
    eq.push_back(hc);
`endif
    chk_seq("rst", eq);
    chk_cfg("rst");
    chk("rst_no_vld", vld_yaw.size(), 0);
`ifdef INERT_HOST_PORT_EN
    chk("rst_gnt_total", gnt_total, 1);
`else
    chk("rst_no_gnt", gnt_total, 0);
`endif

    chk("protocol_violations", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inert_sched.md
# inert_sched

Command sequencer and arbiter for the team's SPI monarch serving the inertial sensor. After reset it waits out sensor power-up, issues the fixed configuration writes, then reads a 16-bit yaw rate on every sensor data-ready interrupt. It also shares the SPI link with an optional host requester. The block sits between the SPI monarch (it drives `snd`/`cmd` and observes `done`/`resp`) and the heading/control logic.

## Interface
- `INIT_CYC`, default 65535: clk cycles from reset release to the first config write (16-bit count).
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `INT`  in  1  sensor data-ready; asynchronous, active-high.
- `snd`  out  1  one-cycle pulse that starts a monarch transaction.
- `cmd`  out  16  command to the monarch; stable from the `snd` cycle until completion.
- `done`  in  1  monarch done; rises at transaction end and stays high until the next `snd`.
- `resp`  in  16  monarch response; valid while `done` is high.
- `host_req`  in  1  host transaction request, level.
- `host_cmd`  in  16  host command; held with `host_req`.
- `host_gnt`  out  1  one-cycle pulse: `host_cmd` captured and issued.
- `host_done`  out  1  one-cycle pulse: host transaction complete.
- `host_resp`  out  16  registered `resp` of the last host transaction.
- `yaw_rt`  out  16  latest yaw rate, {high byte, low byte}.
- `vld`  out  1  one-cycle pulse when `yaw_rt` updates.

## Operation
- Completion is the rising edge of `done` (`done & ~done_q`). The level of `done` is never used, because it is stale during the issue cycle.
- `INT` passes through a 2-flop synchronizer plus rising-edge detect. An edge sets `int_pend`; issuing RD_L clears it. Edges while pending collapse into one read. An edge in the same cycle as the clear leaves `int_pend` set.
- States:
  - PWR_WAIT: count `INIT_CYC`, then go to CFG.
  - CFG: issue writes 16'h0D02, 16'h1053, 16'h1150, 16'h1460 in order, with a 2-bit index. Each write waits for completion, then the next is issued. After the fourth completes, go to IDLE.
  - IDLE: if `int_pend`, go to RD_L. Else if `host_req`, go to HOST. Else stay.
  - RD_L: issue 16'hA600; on completion capture `resp[7:0]` as the low byte, then go to RD_H.
  - RD_H: issue 16'hA700; on completion load `yaw_rt` = {`resp[7:0]`, low byte}, pulse `vld`, and return to IDLE.
  - HOST: issue `host_cmd` and pulse `host_gnt`. On completion, register `host_resp` = `resp`, pulse `host_done`, and return to IDLE.
- Priority in IDLE: sensor read over host. A host request is never preempted mid-transaction. An `INT` arriving during HOST is serviced next.
- At most one monarch transaction is outstanding. `snd` never pulses while waiting for completion.
- `host_req` during PWR_WAIT or CFG is held off and not dropped. The host must keep `host_req` and `host_cmd` stable until `host_gnt`.

## Timing
- Reset values: `snd`=0, `cmd`=16'h0000, `host_gnt`=0, `host_done`=0, `host_resp`=0, `yaw_rt`=0, `vld`=0, state=PWR_WAIT, `int_pend`=0.
- All outputs are registered.
- The first `snd` occurs `INIT_CYC`+1 cycles after reset release.
- Issue to re-issue: `snd` for the next command comes exactly 1 cycle after the completion edge.
- `INT` edge to RD_L `snd`: at minimum 3 cycles when idle (2 sync + 1 edge/decision).
- `host_gnt` is in the same cycle as the host `snd`. `host_done` and the updated `host_resp` are visible 1 cycle after the completion edge.
- `vld` and the new `yaw_rt` are visible 1 cycle after the RD_H completion edge.
- Reset mid-transaction returns the block to PWR_WAIT. Power-up wait and config are repeated in full, and any pending host request is re-arbitrated.

## Configuration
- `INERT_HOST_PORT_EN` defined: host arbitration and the HOST state are present as described.
- Not defined: `host_req`/`host_cmd` are ignored. `host_gnt`, `host_done`, and `host_resp` are tied to 0. IDLE services only `int_pend`. Ports remain present.

## Structure
- `inert_pkg`: state enum, the four config command constants, RD_L/RD_H read commands, `INIT_CYC` default.
- Sub-module `int_sync`: 2-flop synchronizer plus rising-edge pulse for `INT`, reused by other async sensor lines.

## Test plan
- Release reset with `INIT_CYC`=20 and an SPI monarch model → first `snd` at cycle 21; `cmd` sequence 0D02, 1053, 1150, 1460, one `snd` per completion.
- After config, pulse `INT`; model returns 0x34 then 0x12 → `cmd` A600 then A700; `yaw_rt`=16'h1234 with a single `vld` pulse.
- Assert `host_req` with `host_cmd`=16'h8F00 during CFG → no grant until after the 1460 completion; `host_gnt` coincides with `snd`; `host_resp`=model value when `host_done` pulses.
- `host_req` and `INT` edge in the same IDLE window → RD_L/RD_H run first, then HOST. A second `INT` during HOST → a read follows host completion.
- Three `INT` edges during one RD_L → exactly one extra read pair after the current one.
- Assert `rst_n` low during RD_H → all outputs return to reset values; after release, the PWR_WAIT/CFG sequence repeats. Without `INERT_HOST_PORT_EN`, `host_req` never yields `host_gnt`.
